cordic_job_ctrl: RTL and testbench

//  Host-side counterpart of the CORDIC control FSM. Accepts one job (mode) per

---
 rtl/cordic_job_ctrl_if.sv | 27 ++
 rtl/cordic_job_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cordic_job_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_job_ctrl_if.sv
// Job request / result response bundle between a host and cordic_job_ctrl.
interface cordic_job_ctrl_if #(
  parameter int unsigned W = 16
) ();
  logic         req_valid;
  logic         req_ready;
  logic         req_mode;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_x;
  logic [W-1:0] rsp_y;
  logic [W-1:0] rsp_z;
  logic         rsp_mode;
  logic         rsp_err;

  // Host side: issues jobs, consumes results.
  modport master (
    output req_valid, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_x, rsp_y, rsp_z, rsp_mode, rsp_err
  );

  // Controller side: accepts jobs, returns results.
  modport slave (
    input  req_valid, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_x, rsp_y, rsp_z, rsp_mode, rsp_err
  );
endinterface

// File: rtl/cordic_job_ctrl.sv
// Host-side job controller for a CORDIC FSM: accepts one job per handshake,
// pulses start, owns the iteration counter, captures results and guards the
// FSM with a watchdog.
module cordic_job_ctrl #(
  parameter int unsigned W        = 16,
  parameter int unsigned CW       = 4,
  parameter int unsigned ITERS    = 8,
  parameter logic [2:0]  FSM_IDLE = 3'b000,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clka,
  input  logic                reset_n,
  cordic_job_ctrl_if.slave    bus,
  output logic                fsm_start,
  output logic                fsm_mode,
  input  logic [2:0]          fsm_state,
  input  logic                fsm_counter_rst,
  input  logic                fsm_counter_hold,
  output logic [CW-1:0]       counter,
  input  logic [W-1:0]        dp_x,
  input  logic [W-1:0]        dp_y,
  input  logic [W-1:0]        dp_z
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_RESP  = 3'd4
  } ctrl_t;

  ctrl_t           state_q;
  ctrl_t           state_d;
  logic [WDW-1:0]  wd_q;
  logic [WDW-1:0]  wd_d;
  logic [CW-1:0]   counter_d;
  logic            accept_c;
  logic            capture_c;
  logic            timeout_c;
  logic            watch_c;
  logic            done_c;

  // Job is finished once the counter hit its terminal value and the FSM is back idle.
  assign done_c = (counter == CW'(ITERS)) && (fsm_state == FSM_IDLE);

  // Iteration counter: clear beats hold; counts only while running, saturating.
  always_comb begin
    counter_d = counter;
    if (fsm_counter_rst) begin
      counter_d = '0;
    end else if (fsm_counter_hold) begin
      counter_d = counter;
    end else if ((state_q == S_RUN) && (counter < CW'(ITERS))) begin
      counter_d = counter + CW'(1);
    end
  end

  // Control FSM next-state, watchdog and capture strobes.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    watch_c   = (state_q == S_ARM) || (state_q == S_RUN);
    if (watch_c) begin
      wd_d      = wd_q + WDW'(1);
      timeout_c = (wd_d == WDW'(TIMEOUT));
    end
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept_c = 1'b1;
          wd_d     = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        state_d = S_ARM;
      end
      S_ARM: begin
        if (timeout_c) begin
          state_d = S_RESP;
        end else if (fsm_state != FSM_IDLE) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (timeout_c) begin
          state_d = S_RESP;
        end else if (done_c) begin
          capture_c = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_valid && bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter and watchdog registers.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
      wd_q    <= '0;
    end else begin
      counter <= counter_d;
      wd_q    <= wd_d;
    end
  end

  // Registered handshake/start flags follow the upcoming state.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      fsm_start     <= 1'b0;
      fsm_mode      <= 1'b0;
    end else begin
      bus.req_ready <= (state_d == S_IDLE);
      bus.rsp_valid <= (state_d == S_RESP);
      fsm_start     <= (state_d == S_START);
      if (accept_c) begin
        fsm_mode <= bus.req_mode;
      end
    end
  end

  // Result capture; a timeout zeroes the data and wins over a same-cycle completion.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      bus.rsp_x    <= '0;
      bus.rsp_y    <= '0;
      bus.rsp_z    <= '0;
      bus.rsp_mode <= 1'b0;
      bus.rsp_err  <= 1'b0;
    end else if (timeout_c) begin
      bus.rsp_x    <= '0;
      bus.rsp_y    <= '0;
      bus.rsp_z    <= '0;
      bus.rsp_mode <= fsm_mode;
      bus.rsp_err  <= 1'b1;
    end else if (capture_c) begin
      bus.rsp_x    <= dp_x;
      bus.rsp_y    <= dp_y;
      bus.rsp_z    <= dp_z;
      bus.rsp_mode <= fsm_mode;
      bus.rsp_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_job_ctrl.sv
// Self-checking bench for cordic_job_ctrl: job-level reference model,
// a small CORDIC FSM stand-in, directed scenarios and a random phase.
module tb_cordic_job_ctrl;

  localparam int unsigned W        = 16;
  localparam int unsigned CW       = 4;
  localparam int unsigned ITERS    = 8;
  localparam logic [2:0]  FSM_IDLE = 3'b000;
  localparam int unsigned TIMEOUT  = 64;

  logic          clka = 1'b0;
  logic          reset_n;
  logic          fsm_start;
  logic          fsm_mode;
  logic [2:0]    fsm_state;
  logic          fsm_counter_rst;
  logic          fsm_counter_hold;
  logic [CW-1:0] counter;
  logic [W-1:0]  dp_x, dp_y, dp_z;

  cordic_job_ctrl_if #(.W(W)) bus ();

  cordic_job_ctrl #(
    .W(W), .CW(CW), .ITERS(ITERS), .FSM_IDLE(FSM_IDLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clka             (clka),
    .reset_n          (reset_n),
    .bus              (bus),
    .fsm_start        (fsm_start),
    .fsm_mode         (fsm_mode),
    .fsm_state        (fsm_state),
    .fsm_counter_rst  (fsm_counter_rst),
    .fsm_counter_hold (fsm_counter_hold),
    .counter          (counter),
    .dp_x             (dp_x),
    .dp_y             (dp_y),
    .dp_z             (dp_z)
  );

  always #5 clka = ~clka;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  int cyc      = 0;

  // Job-level reference: what the outputs must be, derived from the job rules.
  typedef struct {
    logic        ready;
    logic        start;
    logic        mode;
    logic [3:0]  cnt;
    logic        rvalid;
    logic [15:0] rx, ry, rz;
    logic        rmode;
    logic        rerr;
    logic        active;     // job accepted and not concluded
    logic        started;    // start pulse already issued
    logic        busy_seen;  // FSM has left idle for this job
    int          elapsed;    // cycles spent waiting on the FSM
  } mstate_t;

  mstate_t m, n;
  int      m_accepts = 0;
  logic    mode_q[$];

  // Stand-in CORDIC FSM controls.
  logic env_busy, env_hang, noise, dp_fix, force_hold, force_rst;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m.ready = 0; m.start = 0; m.mode = 0; m.cnt = 0;
    m.rvalid = 0; m.rx = 0; m.ry = 0; m.rz = 0; m.rmode = 0; m.rerr = 0;
    m.active = 0; m.started = 0; m.busy_seen = 0; m.elapsed = 0;
    mode_q.delete();
  endfunction

  function automatic void model_next();
    n = m;
    n.start = 1'b0;
    if (fsm_counter_rst)       n.cnt = 4'd0;
    else if (fsm_counter_hold) n.cnt = m.cnt;
    else if (m.active && m.busy_seen && (m.cnt < 4'(ITERS))) n.cnt = m.cnt + 4'd1;
    if (m.active) begin
      if (!m.started) begin
        n.started = 1'b1;
      end else begin
        n.elapsed = m.elapsed + 1;
        if (n.elapsed == int'(TIMEOUT)) begin
          n.active = 0; n.rvalid = 1; n.rmode = m.mode; n.rerr = 1;
          n.rx = 0; n.ry = 0; n.rz = 0;
        end else if (m.busy_seen && (m.cnt == 4'(ITERS)) && (fsm_state == FSM_IDLE)) begin
          n.active = 0; n.rvalid = 1; n.rmode = m.mode; n.rerr = 0;
          n.rx = dp_x; n.ry = dp_y; n.rz = dp_z;
        end else if (!m.busy_seen && (fsm_state != FSM_IDLE)) begin
          n.busy_seen = 1'b1;
        end
      end
    end else if (m.rvalid) begin
      if (bus.rsp_ready) n.rvalid = 1'b0;
    end else if (bus.req_valid && m.ready) begin
      n.active = 1; n.started = 0; n.busy_seen = 0; n.elapsed = 0;
      n.mode = bus.req_mode; n.start = 1'b1;
      mode_q.push_back(bus.req_mode);
      m_accepts++;
    end
    n.ready = !n.active && !n.rvalid;
  endfunction

  task automatic compare();
    check("req_ready", 32'(bus.req_ready), 32'(m.ready));
    check("fsm_start", 32'(fsm_start),     32'(m.start));
    check("fsm_mode",  32'(fsm_mode),      32'(m.mode));
    check("counter",   32'(counter),       32'(m.cnt));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m.rvalid));
    if (m.rvalid) begin
      check("rsp_x",    32'(bus.rsp_x),    32'(m.rx));
      check("rsp_y",    32'(bus.rsp_y),    32'(m.ry));
      check("rsp_z",    32'(bus.rsp_z),    32'(m.rz));
      check("rsp_mode", 32'(bus.rsp_mode), 32'(m.rmode));
      check("rsp_err",  32'(bus.rsp_err),  32'(m.rerr));
    end
  endtask

  function automatic void env_react();
    if (!env_busy) begin
      fsm_state        = FSM_IDLE;
      fsm_counter_rst  = force_rst;
      fsm_counter_hold = force_hold;
      if (fsm_start) begin
        env_busy        = 1'b1;
        fsm_state       = 3'($urandom_range(1, 7));
        fsm_counter_rst = 1'b1;
        if (dp_fix) begin
          dp_x = 16'h1234; dp_y = 16'h5678; dp_z = 16'h9abc;
        end else begin
          dp_x = 16'($urandom); dp_y = 16'($urandom); dp_z = 16'($urandom);
        end
      end
    end else begin
      fsm_counter_rst  = force_rst  | (noise && ($urandom_range(0, 19) == 0));
      fsm_counter_hold = force_hold | (noise && ($urandom_range(0, 7) == 0));
      if (!env_hang && (counter == 4'(ITERS))) begin
        env_busy  = 1'b0;
        fsm_state = FSM_IDLE;
      end else begin
        fsm_state = 3'($urandom_range(1, 7));
      end
    end
  endfunction

  // One clock: scoreboard the response handshake, advance the model, compare.
  task automatic tick();
    logic exp_mode;
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      n_rsp++;
      if (mode_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_unexpected_rsp got=response expected=none cycle=%0d", cyc);
      end else begin
        exp_mode = mode_q.pop_front();
        check("sb_rsp_mode", 32'(bus.rsp_mode), 32'(exp_mode));
      end
    end
    model_next();
    @(posedge clka);
    m = n;
    cyc++;
    @(negedge clka);
    compare();
    env_react();
  endtask

  task automatic wait_rsp(input string name, input int budget, output int waited);
    waited = 0;
    while (bus.rsp_valid !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    if (bus.rsp_valid !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL %s got=no rsp_valid expected=rsp_valid within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_cnt(input string name, input logic [3:0] val, input int budget);
    int k = 0;
    while (counter !== val && k < budget) begin
      tick();
      k++;
    end
    if (counter !== val) begin
      n_checks++; n_fail++;
      $display("FAIL %s got=counter %0d expected=counter %0d within %0d cycles", name, counter, val, budget);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int       waited, t0, rsp0, acc0;
    logic [15:0] sx, sy, sz;

    reset_n = 1'b0;
    bus.req_valid = 0; bus.req_mode = 0; bus.rsp_ready = 0;
    fsm_state = FSM_IDLE; fsm_counter_rst = 0; fsm_counter_hold = 0;
    dp_x = 0; dp_y = 0; dp_z = 0;
    env_busy = 0; env_hang = 0; noise = 0; dp_fix = 0; force_hold = 0; force_rst = 0;
    model_reset();
    repeat (3) @(posedge clka);
    @(negedge clka);
    compare();
    reset_n = 1'b1;
    tick();
    check("init_req_ready", 32'(bus.req_ready), 32'd1);
    check("init_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Rotation job with known datapath results.
    dp_fix = 1;
    bus.req_valid = 1; bus.req_mode = 0;
    tick();
    bus.req_valid = 0;
    check("rot_start_c1", 32'(fsm_start), 32'd1);
    tick();
    check("rot_start_c2", 32'(fsm_start), 32'd0);
    wait_rsp("rot_rsp", 100, waited);
    check("rot_rsp_x",    32'(bus.rsp_x),    32'h1234);
    check("rot_rsp_y",    32'(bus.rsp_y),    32'h5678);
    check("rot_rsp_mode", 32'(bus.rsp_mode), 32'd0);
    check("rot_rsp_err",  32'(bus.rsp_err),  32'd0);
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;
    dp_fix = 0;

    // Vectoring job held under backpressure; a second request must be ignored.
    bus.req_valid = 1; bus.req_mode = 1;
    tick();
    bus.req_valid = 0;
    wait_rsp("vec_rsp", 100, waited);
    sx = m.rx; sy = m.ry; sz = m.rz;
    bus.req_valid = 1; bus.req_mode = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_x",     32'(bus.rsp_x),     32'(sx));
      check("bp_rsp_y",     32'(bus.rsp_y),     32'(sy));
      check("bp_rsp_z",     32'(bus.rsp_z),     32'(sz));
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    check("bp_rsp_mode", 32'(bus.rsp_mode), 32'd1);
    bus.req_mode = 1; bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;
    check("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_after_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 0;
    check("next_start", 32'(fsm_start), 32'd1);
    check("next_mode",  32'(fsm_mode),  32'd1);

    // Counter controls on the job just started.
    wait_cnt("cnt_reach5", 4'd5, 40);
    force_hold = 1; fsm_counter_hold = 1;
    tick();
    check("cnt_hold_a", 32'(counter), 32'd5);
    tick();
    check("cnt_hold_b", 32'(counter), 32'd5);
    force_rst = 1; fsm_counter_rst = 1;
    tick();
    check("cnt_rst_over_hold", 32'(counter), 32'd0);
    force_rst = 0; force_hold = 0; fsm_counter_rst = 0; fsm_counter_hold = 0;
    wait_rsp("cnt_rsp", 100, waited);
    check("cnt_sat", 32'(counter), 32'(ITERS));
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;

    // Hung FSM trips the watchdog.
    env_hang = 1;
    bus.req_valid = 1; bus.req_mode = 1'($urandom);
    t0 = cyc;
    tick();
    bus.req_valid = 0;
    wait_rsp("hang_rsp", 120, waited);
    check("hang_latency", 32'(cyc - t0), 32'(TIMEOUT + 2));
    check("hang_err",   32'(bus.rsp_err), 32'd1);
    check("hang_x",     32'(bus.rsp_x),   32'd0);
    check("hang_y",     32'(bus.rsp_y),   32'd0);
    check("hang_z",     32'(bus.rsp_z),   32'd0);
    check("hang_cnt",   32'(counter),     32'(ITERS));
    env_hang = 0;
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;

    // Back-to-back jobs with the response side always ready.
    rsp0 = n_rsp; acc0 = m_accepts;
    bus.rsp_ready = 1; bus.req_valid = 1;
    for (int i = 0; i < 300 && n_rsp < rsp0 + 6; i++) begin
      if (m_accepts - acc0 >= 6) bus.req_valid = 0;
      bus.req_mode = 1'($urandom);
      tick();
    end
    bus.req_valid = 0; bus.rsp_ready = 0;
    check("b2b_rsp_count", 32'(n_rsp - rsp0), 32'd6);
    tick();

    // Reset asserted in the middle of a running job.
    bus.req_valid = 1; bus.req_mode = 1;
    tick();
    bus.req_valid = 0;
    wait_cnt("rst_reach3", 4'd3, 40);
    reset_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_fsm_start", 32'(fsm_start),     32'd0);
    check("rst_fsm_mode",  32'(fsm_mode),      32'd0);
    check("rst_counter",   32'(counter),       32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_x",     32'(bus.rsp_x),     32'd0);
    check("rst_rsp_mode",  32'(bus.rsp_mode),  32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    env_busy = 0; fsm_state = FSM_IDLE; fsm_counter_rst = 0; fsm_counter_hold = 0;
    model_reset();
    repeat (2) @(posedge clka);
    @(negedge clka);
    reset_n = 1'b1;
    tick();
    check("rst_release_ready", 32'(bus.req_ready), 32'd1);
    check("rst_release_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (12) tick();

    // Random traffic with counter-control noise.
    noise = 1;
    for (int i = 0; i < 600; i++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_mode  = 1'($urandom);
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    noise = 0;
    bus.req_valid = 0; bus.rsp_ready = 1;
    for (int i = 0; i < 200 && (m.active || m.rvalid); i++) tick();
    tick();
    check("drain_queue_empty", 32'(mode_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
